// File: rtl/debug_trace_buffer_pkg.sv
// Shared trace types (the DebugTypes set): state encoding, stamp width and entry-width helper.
// Entry width depends on RSD_DEBUG_TRACE_TIMESTAMP_EN.
package debug_trace_buffer_pkg;

  localparam int TRACE_STAMP_WIDTH = 16;

  typedef enum logic [2:0] {
    TS_IDLE   = 3'd0,
    TS_ARMED  = 3'd1,
    TS_POST   = 3'd2,
    TS_FROZEN = 3'd3,
    TS_DRAIN  = 3'd4
  } TraceState;

  // The packed TraceEntry depends on module parameters, so it is declared in the
  // top; this gives consumers its width.
  function automatic int trace_entry_width(int lanes, int pc_w);
`ifdef RSD_DEBUG_TRACE_TIMESTAMP_EN
    return lanes + lanes * pc_w + TRACE_STAMP_WIDTH;
`else
    return lanes + lanes * pc_w;
`endif
  endfunction

endpackage

// File: rtl/debug_trace_buffer_if.sv
// Drain port of the trace buffer: start pulse plus valid/ready read stream.
interface debug_trace_buffer_if #(
  parameter int ENTRY_W = 66
);
  logic               rdStart;
  logic               rdReady;
  logic               rdValid;
  logic [ENTRY_W-1:0] rdData;
  logic               rdLast;

  modport master (input rdStart, input rdReady, output rdValid, output rdData, output rdLast);
  modport slave  (output rdStart, output rdReady, input rdValid, input rdData, input rdLast);
endinterface

// File: rtl/debug_trace_buffer_ram.sv
// trace_entry_ram: DEPTH x W simple dual-port RAM, one write port, registered read port.
// Read register resets to zero and only updates on re_i, so it holds during stalls.
module trace_entry_ram #(
  parameter int DEPTH = 16,
  parameter int W     = 66
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     we_i,
  input  logic [$clog2(DEPTH)-1:0] waddr_i,
  input  logic [W-1:0]             wdata_i,
  input  logic                     re_i,
  input  logic [$clog2(DEPTH)-1:0] raddr_i,
  output logic [W-1:0]             rdata_o
);
  logic [W-1:0] mem_q [DEPTH];
  logic [W-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  always_ff @(posedge clk) begin
    if (!rst)      rdata_q <= '0;
    else if (re_i) rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;
endmodule

// File: rtl/debug_trace_buffer.sv
// Commit-trace capture: arm, trigger (PC match / external), post-trigger window, freeze, drain oldest-first.
// Macros: RSD_DEBUG_TRACE_TIMESTAMP_EN adds a 16-bit stamp per entry; RSD_DISABLE_DEBUG_REGISTER ties outputs to 0.
module debug_trace_buffer
  import debug_trace_buffer_pkg::*;
#(
  parameter int DEPTH      = 16,
  parameter int LANES      = 2,
  parameter int POST_DEPTH = 4,
  parameter int PC_W       = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       arm_i,
  input  logic                       disarm_i,
  input  logic [PC_W-1:0]            trigPC_i,
  input  logic                       trigPCEn_i,
  input  logic                       extTrigger_i,
  input  logic [LANES-1:0]           cmValid_i,
  input  logic [LANES-1:0][PC_W-1:0] cmPC_i,
  debug_trace_buffer_if.master       rd,
  output logic [2:0]                 state_o,
  output logic                       triggered_o,
  output logic [$clog2(DEPTH):0]     entryCount_o
);
  localparam int AW = $clog2(DEPTH);

  typedef struct packed {
    logic [LANES-1:0]           valid;
    logic [LANES-1:0][PC_W-1:0] pc;
`ifdef RSD_DEBUG_TRACE_TIMESTAMP_EN
    logic [TRACE_STAMP_WIDTH-1:0] stamp;
`endif
  } TraceEntry;

  localparam int ENTRY_W = $bits(TraceEntry);

  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [AW-1:0] PTR_LAST = AW'(DEPTH - 1);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW:0]   CNT_TWO  = (AW+1)'(2);
  localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] POST_LD  = AW'(POST_DEPTH);

  TraceState     state_q, state_d;
  logic [AW-1:0] wrPtr_q, wrPtr_d;
  logic [AW-1:0] rdPtr_q, rdPtr_d;
  logic [AW-1:0] postCnt_q, postCnt_d;
  logic [AW:0]   entryCount_q, entryCount_d;
  logic [AW:0]   remaining_q, remaining_d;
  logic          wrapped_q, wrapped_d;
  logic          triggered_q, triggered_d;
  logic          extPend_q, extPend_d;
  logic          rdValid_q, rdValid_d;
  logic          rdLast_q, rdLast_d;
`ifdef RSD_DEBUG_TRACE_TIMESTAMP_EN
  logic [TRACE_STAMP_WIDTH-1:0] stamp_q, stamp_d;
`endif

  logic               we, re;
  logic [AW-1:0]      raddr;
  logic [ENTRY_W-1:0] rdata;
  TraceEntry          wentry;
  logic [LANES-1:0]   lane_hit;
  logic               capture, trig_hit, hs;

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    assign lane_hit[l] = cmValid_i[l] && (cmPC_i[l] == trigPC_i);
  end

  assign capture  = ((state_q == TS_ARMED) || (state_q == TS_POST)) && (|cmValid_i);
  assign trig_hit = (trigPCEn_i && (|lane_hit)) || extTrigger_i || extPend_q;
  assign hs       = rdValid_q && rd.rdReady;

  assign wentry.valid = cmValid_i;
  assign wentry.pc    = cmPC_i;
`ifdef RSD_DEBUG_TRACE_TIMESTAMP_EN
  assign wentry.stamp = stamp_q;
`endif

  always_comb begin
    state_d      = state_q;
    wrPtr_d      = wrPtr_q;
    rdPtr_d      = rdPtr_q;
    postCnt_d    = postCnt_q;
    entryCount_d = entryCount_q;
    remaining_d  = remaining_q;
    wrapped_d    = wrapped_q;
    triggered_d  = triggered_q;
    extPend_d    = extPend_q;
    rdValid_d    = rdValid_q;
    rdLast_d     = rdLast_q;
`ifdef RSD_DEBUG_TRACE_TIMESTAMP_EN
    stamp_d      = stamp_q;
`endif
    we    = 1'b0;
    re    = 1'b0;
    raddr = rdPtr_q;

    unique case (state_q)
      TS_IDLE: begin
        if (arm_i && !disarm_i) begin
          state_d      = TS_ARMED;
          triggered_d  = 1'b0;
          extPend_d    = 1'b0;
          wrPtr_d      = '0;
          entryCount_d = '0;
          wrapped_d    = 1'b0;
`ifdef RSD_DEBUG_TRACE_TIMESTAMP_EN
          stamp_d      = TRACE_STAMP_WIDTH'(1);
`endif
        end
      end
      TS_ARMED, TS_POST: begin
        if (disarm_i) begin
          state_d      = TS_IDLE;
          wrPtr_d      = '0;
          entryCount_d = '0;
          wrapped_d    = 1'b0;
          extPend_d    = 1'b0;
        end else if (capture) begin
          we      = 1'b1;
          wrPtr_d = wrPtr_q + PTR_ONE;
          if (wrPtr_q == PTR_LAST)       wrapped_d    = 1'b1;
          if (entryCount_q != CNT_FULL)  entryCount_d = entryCount_q + CNT_ONE;
`ifdef RSD_DEBUG_TRACE_TIMESTAMP_EN
          stamp_d = TRACE_STAMP_WIDTH'(1);
`endif
          if (state_q == TS_ARMED) begin
            if (trig_hit) begin
              triggered_d = 1'b1;
              extPend_d   = 1'b0;
              postCnt_d   = POST_LD;
              state_d     = (POST_DEPTH == 0) ? TS_FROZEN : TS_POST;
            end
          end else begin
            postCnt_d = postCnt_q - PTR_ONE;
            if (postCnt_q == PTR_ONE) state_d = TS_FROZEN;
          end
        end else begin
          // An external trigger without a valid lane waits for the next capture.
          if ((state_q == TS_ARMED) && extTrigger_i) extPend_d = 1'b1;
`ifdef RSD_DEBUG_TRACE_TIMESTAMP_EN
          if (stamp_q != {TRACE_STAMP_WIDTH{1'b1}}) stamp_d = stamp_q + TRACE_STAMP_WIDTH'(1);
`endif
        end
      end
      TS_FROZEN: begin
        if (rd.rdStart) begin
          state_d     = TS_DRAIN;
          re          = 1'b1;
          raddr       = wrapped_q ? wrPtr_q : '0;
          rdPtr_d     = raddr + PTR_ONE;
          remaining_d = entryCount_q;
          rdValid_d   = 1'b1;
          rdLast_d    = (entryCount_q == CNT_ONE);
        end
      end
      TS_DRAIN: begin
        if (hs) begin
          if (remaining_q == CNT_ONE) begin
            state_d      = TS_IDLE;
            rdValid_d    = 1'b0;
            rdLast_d     = 1'b0;
            remaining_d  = '0;
            wrPtr_d      = '0;
            entryCount_d = '0;
            wrapped_d    = 1'b0;
          end else begin
            // rdPtr_q always points at the entry after the one being presented.
            re          = 1'b1;
            raddr       = rdPtr_q;
            rdPtr_d     = rdPtr_q + PTR_ONE;
            remaining_d = remaining_q - CNT_ONE;
            rdLast_d    = (remaining_q == CNT_TWO);
          end
        end
      end
      default: state_d = TS_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= TS_IDLE;
      wrPtr_q      <= '0;
      rdPtr_q      <= '0;
      postCnt_q    <= '0;
      entryCount_q <= '0;
      remaining_q  <= '0;
      wrapped_q    <= 1'b0;
      triggered_q  <= 1'b0;
      extPend_q    <= 1'b0;
      rdValid_q    <= 1'b0;
      rdLast_q     <= 1'b0;
`ifdef RSD_DEBUG_TRACE_TIMESTAMP_EN
      stamp_q      <= '0;
`endif
    end else begin
      state_q      <= state_d;
      wrPtr_q      <= wrPtr_d;
      rdPtr_q      <= rdPtr_d;
      postCnt_q    <= postCnt_d;
      entryCount_q <= entryCount_d;
      remaining_q  <= remaining_d;
      wrapped_q    <= wrapped_d;
      triggered_q  <= triggered_d;
      extPend_q    <= extPend_d;
      rdValid_q    <= rdValid_d;
      rdLast_q     <= rdLast_d;
`ifdef RSD_DEBUG_TRACE_TIMESTAMP_EN
      stamp_q      <= stamp_d;
`endif
    end
  end

  trace_entry_ram #(
    .DEPTH (DEPTH),
    .W     (ENTRY_W)
  ) u_ram (
    .clk     (clk),
    .rst     (rst),
    .we_i    (we),
    .waddr_i (wrPtr_q),
    .wdata_i (wentry),
    .re_i    (re),
    .raddr_i (raddr),
    .rdata_o (rdata)
  );

`ifdef RSD_DISABLE_DEBUG_REGISTER
  assign rd.rdValid   = 1'b0;
  assign rd.rdData    = '0;
  assign rd.rdLast    = 1'b0;
  assign state_o      = '0;
  assign triggered_o  = 1'b0;
  assign entryCount_o = '0;
`else
  assign rd.rdValid   = rdValid_q;
  assign rd.rdData    = rdata;
  assign rd.rdLast    = rdLast_q;
  assign state_o      = state_q;
  assign triggered_o  = triggered_q;
  assign entryCount_o = entryCount_q;
`endif
endmodule

// File: tb/tb_debug_trace_buffer.sv
// Directed bench for debug_trace_buffer (DEPTH=8, LANES=2, POST_DEPTH=3).
// Timestamp scenario runs only with RSD_DEBUG_TRACE_TIMESTAMP_EN defined.
module tb_debug_trace_buffer;
  import debug_trace_buffer_pkg::*;

  localparam int DEPTH = 8;
  localparam int LANES = 2;
  localparam int POSTD = 3;
  localparam int PCW   = 32;
  localparam int EW    = trace_entry_width(LANES, PCW);
`ifdef RSD_DEBUG_TRACE_TIMESTAMP_EN
  localparam int SW = TRACE_STAMP_WIDTH;
`else
  localparam int SW = 0;
`endif

  logic                      clk = 1'b0;
  logic                      rst = 1'b0;
  logic                      arm = 1'b0, disarm = 1'b0, trigPCEn = 1'b0, extTrig = 1'b0;
  logic [PCW-1:0]            trigPC = '0;
  logic [LANES-1:0]          cmValid = '0;
  logic [LANES-1:0][PCW-1:0] cmPC = '0;
  logic [2:0]                state;
  logic                      triggered;
  logic [3:0]                entryCount;
  int                        nerr = 0, nchk = 0;

  debug_trace_buffer_if #(.ENTRY_W(EW)) rdif();

  always #5 clk = ~clk;

  debug_trace_buffer #(
    .DEPTH(DEPTH), .LANES(LANES), .POST_DEPTH(POSTD), .PC_W(PCW)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .arm_i        (arm),
    .disarm_i     (disarm),
    .trigPC_i     (trigPC),
    .trigPCEn_i   (trigPCEn),
    .extTrigger_i (extTrig),
    .cmValid_i    (cmValid),
    .cmPC_i       (cmPC),
    .rd           (rdif),
    .state_o      (state),
    .triggered_o  (triggered),
    .entryCount_o (entryCount)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nchk++;
    if (obs !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] pc0();
    return rdif.rdData[SW +: 32];
  endfunction
  function automatic logic [31:0] pc1();
    return rdif.rdData[SW+32 +: 32];
  endfunction
  function automatic logic [1:0] mask();
    return rdif.rdData[SW+64 +: 2];
  endfunction

  task automatic pulse_arm;
    arm = 1'b1;
    tick();
    arm = 1'b0;
  endtask

  // Single-lane commit on lane 0 for one cycle.
  task automatic commit(input logic [31:0] pc, input logic ext);
    cmValid = 2'b01;
    cmPC[0] = pc;
    cmPC[1] = '0;
    extTrig = ext;
    tick();
    cmValid = '0;
    extTrig = 1'b0;
  endtask

  // Drain with rdReady held high; entry k must carry base + 4k on lane 0.
  task automatic drain(input string tag, input int n, input logic [31:0] base);
    rdif.rdStart = 1'b1;
    tick();
    rdif.rdStart = 1'b0;
    rdif.rdReady = 1'b1;
    check({tag, "_state"}, 64'(state), 64'(TS_DRAIN));
    for (int k = 0; k < n; k++) begin
      check({tag, "_valid"}, 64'(rdif.rdValid), 64'(1));
      check({tag, "_pc"}, 64'(pc0()), 64'(base + 32'(4 * k)));
      check({tag, "_last"}, 64'(rdif.rdLast), 64'(k == n - 1));
      tick();
    end
    rdif.rdReady = 1'b0;
    check({tag, "_idle"}, 64'(state), 64'(TS_IDLE));
    check({tag, "_rdv0"}, 64'(rdif.rdValid), 64'(0));
    check({tag, "_cnt0"}, 64'(entryCount), 64'(0));
  endtask

  initial begin
    bit pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    int idx, c;
    rdif.rdStart = 1'b0;
    rdif.rdReady = 1'b0;

    // 1. reset with commits present
    cmValid = 2'b11;
    repeat (3) tick();
    check("rst_state", 64'(state), 64'(TS_IDLE));
    check("rst_cnt", 64'(entryCount), 64'(0));
    check("rst_rdv", 64'(rdif.rdValid), 64'(0));
    check("rst_rdl", 64'(rdif.rdLast), 64'(0));
    check("rst_trg", 64'(triggered), 64'(0));
    check("rst_data", 64'(rdif.rdData[63:0]), 64'(0));
    cmValid = '0;
    rst = 1'b1;
    tick();
    check("idle_nocap", 64'(entryCount), 64'(0));

    // 2. PC trigger on 0x108, three post entries, no wrap
    trigPC = 32'h108;
    trigPCEn = 1'b1;
    pulse_arm();
    check("pc_armed", 64'(state), 64'(TS_ARMED));
    for (int i = 0; i < 6; i++) begin
      commit(32'h100 + 32'(4 * i), 1'b0);
      if (i == 2) check("pc_post", 64'(state), 64'(TS_POST));
    end
    check("pc_frozen", 64'(state), 64'(TS_FROZEN));
    check("pc_cnt", 64'(entryCount), 64'(6));
    check("pc_trg", 64'(triggered), 64'(1));
    commit(32'h500, 1'b0);
    check("pc_frz_ign", 64'(entryCount), 64'(6));
    drain("pc", 6, 32'h100);

    // 3. wrap: 20 commits, external trigger on the 15th (0x38)
    trigPCEn = 1'b0;
    pulse_arm();
    check("wr_trgclr", 64'(triggered), 64'(0));
    for (int i = 0; i < 20; i++) begin
      commit(32'(4 * i), i == 14);
      if (i == 9) check("wr_sat", 64'(entryCount), 64'(8));
    end
    check("wr_frozen", 64'(state), 64'(TS_FROZEN));
    check("wr_cnt", 64'(entryCount), 64'(8));
    drain("wr", 8, 32'h28);

    // 4. arm+disarm in IDLE, then disarm during POST
    arm = 1'b1;
    disarm = 1'b1;
    tick();
    arm = 1'b0;
    disarm = 1'b0;
    check("sim_idle", 64'(state), 64'(TS_IDLE));
    trigPC = 32'h200;
    trigPCEn = 1'b1;
    pulse_arm();
    commit(32'h200, 1'b0);
    check("dis_post", 64'(state), 64'(TS_POST));
    commit(32'h204, 1'b0);
    disarm = 1'b1;
    cmValid = 2'b01;
    cmPC[0] = 32'h208;
    tick();
    disarm = 1'b0;
    cmValid = '0;
    check("dis_idle", 64'(state), 64'(TS_IDLE));
    check("dis_cnt", 64'(entryCount), 64'(0));

    // latched external trigger, both lanes, then disarm/arm ignored in FROZEN
    trigPCEn = 1'b0;
    pulse_arm();
    extTrig = 1'b1;
    tick();
    extTrig = 1'b0;
    check("ext_wait", 64'(state), 64'(TS_ARMED));
    for (int i = 0; i < 4; i++) begin
      cmValid = 2'b11;
      cmPC[0] = 32'h300 + 32'(4 * i);
      cmPC[1] = 32'h1300 + 32'(4 * i);
      tick();
      if (i == 0) check("ext_post", 64'(state), 64'(TS_POST));
    end
    cmValid = '0;
    check("ext_frozen", 64'(state), 64'(TS_FROZEN));
    disarm = 1'b1;
    arm = 1'b1;
    tick();
    disarm = 1'b0;
    arm = 1'b0;
    check("frz_dis_ign", 64'(state), 64'(TS_FROZEN));
    check("frz_cnt", 64'(entryCount), 64'(4));

    // 5. drain under rdReady pattern 1,0,0,1
    rdif.rdStart = 1'b1;
    tick();
    rdif.rdStart = 1'b0;
    idx = 0;
    c = 0;
    while (idx < 4 && c < 40) begin
      rdif.rdReady = pat[c % 4];
      check("bp_valid", 64'(rdif.rdValid), 64'(1));
      check("bp_pc0", 64'(pc0()), 64'(32'h300 + 32'(4 * idx)));
      check("bp_pc1", 64'(pc1()), 64'(32'h1300 + 32'(4 * idx)));
      check("bp_mask", 64'(mask()), 64'(2'b11));
      check("bp_last", 64'(rdif.rdLast), 64'(idx == 3));
      tick();
      if (pat[c % 4]) idx++;
      c++;
    end
    rdif.rdReady = 1'b0;
    check("bp_done", 64'(idx), 64'(4));
    check("bp_idle", 64'(state), 64'(TS_IDLE));

`ifdef RSD_DEBUG_TRACE_TIMESTAMP_EN
    // 6. stamps: capture at arm+5, arm+9, then after a long idle gap
    pulse_arm();
    repeat (4) tick();
    commit(32'h600, 1'b0);
    repeat (3) tick();
    commit(32'h604, 1'b0);
    repeat (70000) @(posedge clk);
    #1;
    commit(32'h608, 1'b1);
    for (int i = 0; i < 3; i++) commit(32'h60C + 32'(4 * i), 1'b0);
    check("ts_frozen", 64'(state), 64'(TS_FROZEN));
    rdif.rdStart = 1'b1;
    tick();
    rdif.rdStart = 1'b0;
    rdif.rdReady = 1'b1;
    check("ts_s0", 64'(rdif.rdData[15:0]), 64'(16'd5));
    tick();
    check("ts_s1", 64'(rdif.rdData[15:0]), 64'(16'd4));
    tick();
    check("ts_s2", 64'(rdif.rdData[15:0]), 64'(16'hFFFF));
    tick();
    check("ts_s3", 64'(rdif.rdData[15:0]), 64'(16'd1));
    repeat (3) tick();
    rdif.rdReady = 1'b0;
    check("ts_idle", 64'(state), 64'(TS_IDLE));
`endif

    // reset mid-capture returns to IDLE with counters cleared
    pulse_arm();
    commit(32'h700, 1'b0);
    rst = 1'b0;
    tick();
    rst = 1'b1;
    check("mid_rst_state", 64'(state), 64'(TS_IDLE));
    check("mid_rst_cnt", 64'(entryCount), 64'(0));

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule

// File: doc/debug_trace_buffer.md
# debug_trace_buffer

Parametrised commit-trace capture for the debug subsystem. It replaces the one-deep, every-cycle debug register snapshot with a circular history of commit-stage records. Capture is armed, a trigger is taken on a PC match or an external event, a programmable number of post-trigger records is kept, and the buffer then freezes. The frozen history is drained oldest-first over a valid/ready port. The block sits beside the debug register block and is fed from the commit-stage taps (per-lane valid and PC).

## Interface
Parameters:
- `DEPTH`, 16: number of trace entries. Power of two, ≥4.
- `LANES`, 2: commit lanes captured per entry (normally `COMMIT_WIDTH`).
- `POST_DEPTH`, 4: entries kept after the trigger entry. Must satisfy 0 ≤ `POST_DEPTH` < `DEPTH`.
- `PC_W`, 32: PC width (normally `PC_WIDTH`).

Ports:
- `clk` in 1: single clock. All state changes on its rising edge.
- `rst` in 1: **reset is synchronous and active-low** (asserted when 0, sampled on the `clk` edge).
- `arm` in 1: pulse; IDLE→ARMED.
- `disarm` in 1: pulse; ARMED/POST→IDLE, discards the history.
- `trigPC` in `PC_W`: PC compare value.
- `trigPCEn` in 1: enables the PC compare.
- `extTrigger` in 1: external trigger.
- `cmValid` in `LANES`: per-lane commit valid.
- `cmPC` in `LANES`×`PC_W`: per-lane committed PC.
- `rdStart` in 1: pulse; FROZEN→DRAIN.
- `rdReady` in 1: consumer ready.
- `rdValid` out 1: read data valid.
- `rdData` out entry width: packed `TraceEntry`.
- `rdLast` out 1: marks the final entry of the drain.
- `state` out 3: current `TraceState`.
- `triggered` out 1: sticky trigger flag, cleared on a new `arm`.
- `entryCount` out log2(`DEPTH`)+1: valid entries held, saturating at `DEPTH`.

## Operation
- FSM states: IDLE, ARMED, POST, FROZEN, DRAIN.
- **Capture cycle:** a cycle with `|cmValid` while in ARMED or POST. That cycle writes one entry {`cmValid` mask, all `cmPC` lanes[, stamp]} at `wrPtr`.
  - `wrPtr` increments modulo `DEPTH`.
  - `entryCount` increments, saturating at `DEPTH`.
  - `wrapped` sets when `wrPtr` wraps from `DEPTH`-1 to 0.
  - Cycles with no valid lane write nothing.
- **Trigger:** in ARMED, a capture cycle where any valid lane has `cmPC`==`trigPC` with `trigPCEn`=1, or `extTrigger`=1 while `|cmValid`.
  - The trigger entry is written and `triggered` sets.
  - If `POST_DEPTH`==0, go to FROZEN. Otherwise load `postCnt`=`POST_DEPTH` and go to POST.
  - `extTrigger` with no valid lane is latched. It fires on the next capture cycle.
- **POST:** each capture cycle decrements `postCnt`. The write that takes it to 0 moves the FSM to FROZEN.
  - Triggers arriving in POST are ignored.
- **FROZEN:** no writes occur. `cmValid` is ignored.
- **DRAIN:**
  - Start pointer: `rdPtr` = `wrapped` ? `wrPtr` : 0.
  - `remaining` = `entryCount`.
  - On each `rdValid && rdReady`, `rdPtr` increments modulo `DEPTH` and `remaining` decrements.
  - `rdLast` = (`remaining`==1).
  - The handshake on the last entry goes to IDLE and clears `wrPtr`, `entryCount` and `wrapped`.
  - `rdStart` with `entryCount`==0 is impossible, because FROZEN always holds ≥1 entry.
- **Input priority:** `disarm` > `arm` > capture.
  - `arm` is ignored outside IDLE.
  - `rdStart` is ignored outside FROZEN.
  - `disarm` is ignored in FROZEN and DRAIN.
- **Reset mid-operation:** immediate return to IDLE. All pointers, counters and flags clear. RAM contents are don't-care.

## Timing
- Reset values:
  - `state`=IDLE.
  - `rdValid`=0, `rdLast`=0.
  - `triggered`=0.
  - `entryCount`=0.
  - `rdData`=0.
- **Capture latency:** an entry written on edge N is counted in `entryCount` after edge N.
- **Trigger latency:** FROZEN/POST is visible on `state` the cycle after the trigger capture.
- **Drain latency:** `rdValid` asserts the cycle after the DRAIN entry edge.
  - `rdData` is registered, one entry per cycle under continuous `rdReady`.
  - `rdData` and `rdLast` hold stable while `rdValid && !rdReady`.
- **Full buffer:** in ARMED, capture continues and overwrites the oldest entry. `entryCount` stays at `DEPTH`.

## Configuration
- `RSD_DEBUG_TRACE_TIMESTAMP_EN` defined:
  - Each entry carries a 16-bit `stamp`: cycles since the previous capture, saturating at 0xFFFF.
  - The first entry after `arm` holds cycles since `arm`.
- `RSD_DEBUG_TRACE_TIMESTAMP_EN` undefined:
  - The field and its counter are absent.
  - `rdData` narrows by 16 bits.
- `RSD_DISABLE_DEBUG_REGISTER` defined: all outputs tie to 0.

## Structure
- `DebugTypes` holds:
  - `TraceState` enum.
  - `TraceEntry` struct, with the stamp field under the macro.
  - `TRACE_STAMP_WIDTH`=16.
- Sub-module `trace_entry_ram`: a `DEPTH`×entry simple dual-port RAM with one write port and a registered read port.
- The FSM, pointers and counters stay in `debug_trace_buffer`.

## Test plan
All scenarios use `DEPTH`=8, `LANES`=2, `POST_DEPTH`=3.
1. **Reset:** hold `rst`=0 for 3 cycles with `cmValid`=2'b11 → `state`=IDLE, `entryCount`=0, `rdValid`=0.
2. **PC trigger, no wrap:** arm, commit PCs 0x100,0x104,… one lane per cycle, `trigPC`=0x108 → FROZEN after 0x114, `entryCount`=6, drain yields 0x100…0x114 in order, `rdLast` on 0x114.
3. **Wrap:** arm, 20 single-lane commits 0x0..0x4C, `extTrigger` on the 15th → 4 entries kept from the trigger, `entryCount`=8, drain starts at the oldest surviving entry.
4. **Simultaneous:** `arm`+`disarm` same cycle in IDLE → stays IDLE. `disarm` during POST → IDLE, `entryCount`=0.
5. **Backpressure:** drain with `rdReady` toggling 1,0,0,1 → `rdData` stable while stalled, no entry lost or duplicated.
6. **Timestamp (macro on):** captures at cycles 5 and 9 after `arm` → stamps 5 and 4. Idle gap >65535 cycles → stamp 0xFFFF.
